// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: op encodings, widths and FSM states.
package mem_stage_pkg;

  localparam int OpLen      = 4;
  localparam int RegAddrLen = 5;
  localparam int CntLen     = 2;
  localparam logic [31:0] ZERO_WORD = 32'h0;

  typedef enum logic [OpLen-1:0] {
    OP_NOP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2,
    OP_LB  = 4'h8, OP_LH  = 4'h9, OP_LW  = 4'hA, OP_LBU = 4'hB, OP_LHU = 4'hC,
    OP_SB  = 4'hD, OP_SH  = 4'hE, OP_SW  = 4'hF
  } op_e;

  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DONE = 2'd2} state_e;

  function automatic logic is_load(logic [OpLen-1:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic logic is_store(logic [OpLen-1:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  // Index of the final byte of the access (n-1).
  function automatic logic [CntLen-1:0] last_byte(logic [OpLen-1:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 2'd0;
      OP_LH, OP_LHU, OP_SH: return 2'd1;
      default:              return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX->MEM instruction, byte-wide memory port and writeback bundle.
// MEM_FWD_EN adds the forwarding pair fwd_addr/fwd_data.
interface mem_stage_if import mem_stage_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BYTE_W = 8
);
  logic [OpLen-1:0]      op_i;
  logic [ADDR_W-1:0]     mem_addr_i;
  logic [DATA_W-1:0]     rd_data_i;
  logic [RegAddrLen-1:0] rd_addr_i;
  logic                  in_valid;
  logic                  mem_req;
  logic                  mem_wr;
  logic [ADDR_W-1:0]     mem_a;
  logic [BYTE_W-1:0]     mem_dout;
  logic                  mem_ack;
  logic [BYTE_W-1:0]     mem_din;
  logic                  wb_valid;
  logic [DATA_W-1:0]     wb_data;
  logic [RegAddrLen-1:0] wb_addr;
  logic                  mem_stall;
`ifdef MEM_FWD_EN
  logic [RegAddrLen-1:0] fwd_addr;
  logic [DATA_W-1:0]     fwd_data;
`endif

  modport slave (
    input  op_i, mem_addr_i, rd_data_i, rd_addr_i, in_valid, mem_ack, mem_din,
    output mem_req, mem_wr, mem_a, mem_dout, wb_valid, wb_data, wb_addr, mem_stall
`ifdef MEM_FWD_EN
    , output fwd_addr, fwd_data
`endif
  );

  modport master (
    output op_i, mem_addr_i, rd_data_i, rd_addr_i, in_valid, mem_ack, mem_din,
    input  mem_req, mem_wr, mem_a, mem_dout, wb_valid, wb_data, wb_addr, mem_stall
`ifdef MEM_FWD_EN
    , input fwd_addr, fwd_data
`endif
  );
endinterface

// File: rtl/mem_stage_load_ext.sv
// Sign/zero extension of an assembled load word according to the load op.
module load_ext import mem_stage_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  logic [OpLen-1:0]  op,
  input  logic [DATA_W-1:0] raw,
  output logic [DATA_W-1:0] ext
);
  always_comb begin
    ext = raw;
    case (op)
      OP_LB:   ext = {{(DATA_W-8){raw[7]}},   raw[7:0]};
      OP_LBU:  ext = {{(DATA_W-8){1'b0}},     raw[7:0]};
      OP_LH:   ext = {{(DATA_W-16){raw[15]}}, raw[15:0]};
      OP_LHU:  ext = {{(DATA_W-16){1'b0}},    raw[15:0]};
      default: ext = raw;
    endcase
  end
endmodule

// File: rtl/mem_stage.sv
// Memory stage: ALU results pass through in one cycle, loads/stores are split
// into little-endian byte transfers. Optional forwarding port under MEM_FWD_EN.
module mem_stage import mem_stage_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BYTE_W = 8
) (
  input logic        clk,
  input logic        rst,
  input logic        rdy,
  mem_stage_if.slave bus
);
  state_e                state_q, state_d;
  logic [CntLen-1:0]     cnt_q, cnt_d, last_q, last_d, nxt;
  logic [OpLen-1:0]      op_q, op_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic [DATA_W-1:0]     buf_q, buf_d;
  logic [RegAddrLen-1:0] rd_q, rd_d;
  logic                  mem_req_q, mem_req_d, mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0]     mem_a_q, mem_a_d;
  logic [BYTE_W-1:0]     mem_dout_q, mem_dout_d;
  logic                  wb_valid_q, wb_valid_d, mem_stall_q, mem_stall_d;
  logic [DATA_W-1:0]     wb_data_q, wb_data_d;
  logic [RegAddrLen-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0]     word_now, ext_word;
  logic                  take_mem;

  assign take_mem = (state_q == IDLE) && bus.in_valid &&
                    (is_load(bus.op_i) || is_store(bus.op_i));
  assign nxt = cnt_q + 1'b1;

  // Load word with the byte arriving this cycle already merged in.
  always_comb begin
    word_now = buf_q;
    word_now[cnt_q*BYTE_W +: BYTE_W] = bus.mem_din;
  end

  load_ext #(.DATA_W(DATA_W)) u_ext (.op(op_q), .raw(word_now), .ext(ext_word));

  always_comb begin
    state_d = state_q; cnt_d = cnt_q; last_d = last_q; op_d = op_q;
    base_d = base_q; buf_d = buf_q; rd_d = rd_q;
    mem_req_d = mem_req_q; mem_wr_d = mem_wr_q; mem_a_d = mem_a_q; mem_dout_d = mem_dout_q;
    wb_valid_d = wb_valid_q; wb_data_d = wb_data_q; wb_addr_d = wb_addr_q;
    mem_stall_d = mem_stall_q;
    if (rdy) begin
      case (state_q)
        IDLE: begin
          wb_valid_d = 1'b0;
          if (take_mem) begin
            state_d = XFER; cnt_d = '0; last_d = last_byte(bus.op_i); op_d = bus.op_i;
            base_d = bus.mem_addr_i; rd_d = bus.rd_addr_i;
            buf_d = is_store(bus.op_i) ? bus.rd_data_i : '0;
            mem_req_d = 1'b1; mem_wr_d = is_store(bus.op_i); mem_a_d = bus.mem_addr_i;
            mem_dout_d = bus.rd_data_i[BYTE_W-1:0]; mem_stall_d = 1'b1;
          end else if (bus.in_valid) begin
            wb_valid_d = 1'b1; wb_data_d = bus.rd_data_i; wb_addr_d = bus.rd_addr_i;
          end
        end
        XFER: if (bus.mem_ack) begin
          if (is_load(op_q)) buf_d = word_now;
          if (cnt_q == last_q) begin
            state_d = DONE; mem_req_d = 1'b0; mem_wr_d = 1'b0; mem_stall_d = 1'b0;
            wb_valid_d = 1'b1;
            wb_data_d = is_load(op_q) ? ext_word : DATA_W'(ZERO_WORD);
            wb_addr_d = is_load(op_q) ? rd_q : '0;
          end else begin
            cnt_d = nxt;
            mem_a_d = base_q + ADDR_W'(nxt);
            mem_dout_d = buf_q[nxt*BYTE_W +: BYTE_W];
          end
        end
        DONE: begin
          wb_valid_d = 1'b0; state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE; cnt_q <= '0; last_q <= '0; op_q <= '0;
      base_q <= '0; buf_q <= '0; rd_q <= '0;
      mem_req_q <= 1'b0; mem_wr_q <= 1'b0; mem_a_q <= '0; mem_dout_q <= '0;
      wb_valid_q <= 1'b0; wb_data_q <= '0; wb_addr_q <= '0; mem_stall_q <= 1'b0;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d; last_q <= last_d; op_q <= op_d;
      base_q <= base_d; buf_q <= buf_d; rd_q <= rd_d;
      mem_req_q <= mem_req_d; mem_wr_q <= mem_wr_d; mem_a_q <= mem_a_d; mem_dout_q <= mem_dout_d;
      wb_valid_q <= wb_valid_d; wb_data_q <= wb_data_d; wb_addr_q <= wb_addr_d;
      mem_stall_q <= mem_stall_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_a     = mem_a_q;
  assign bus.mem_dout  = mem_dout_q;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.wb_addr   = wb_addr_q;
  assign bus.mem_stall = mem_stall_q | take_mem;

`ifdef MEM_FWD_EN
  assign bus.fwd_addr = wb_valid_q ? wb_addr_q : '0;
  assign bus.fwd_data = wb_valid_q ? wb_data_q : '0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: vector table plus scoreboard on writeback, byte-level
// memory log, and hand-written rdy-freeze / reset-abort / busy-ignore sequences.
module tb_mem_stage;
  import mem_stage_pkg::*;

  typedef struct {
    string                 name;
    logic [OpLen-1:0]      op;
    logic [31:0]           addr;
    logic [31:0]           data;
    logic [RegAddrLen-1:0] rd;
    logic [31:0]           exp_data;
    logic [RegAddrLen-1:0] exp_rd;
    int                    exp_stall;
    int                    exp_n;
  } vec_t;

  typedef struct packed {
    logic [31:0]           data;
    logic [RegAddrLen-1:0] rd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  logic ack_en = 1'b1;
  logic [7:0] mem [0:4095];

  mem_stage_if #(.ADDR_W(32), .DATA_W(32), .BYTE_W(8)) bus();

  mem_stage #(.ADDR_W(32), .DATA_W(32), .BYTE_W(8)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus.mem_ack = bus.mem_req & ack_en;
    bus.mem_din = mem[bus.mem_a[11:0]];
  end

  int n_vec = 0;
  int n_fail = 0;
  int stall_cnt = 0;
  int wb_cnt = 0;
  exp_t sb_q[$];
  logic [31:0] log_a[$];
  logic [7:0]  log_d[$];
  vec_t vecs[12];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One clock: observe at the falling edge, return shortly after the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (!rst && rdy) begin
      if (bus.mem_req && bus.mem_ack) begin
        log_a.push_back(bus.mem_a);
        log_d.push_back(bus.mem_dout);
      end
      if (bus.mem_stall) stall_cnt++;
      if (bus.wb_valid) begin
        wb_cnt++;
        if (sb_q.size() == 0) chk("spurious_wb_valid", {31'b0, bus.wb_valid}, 32'h0);
        else begin
          e = sb_q.pop_front();
          chk("wb_data", bus.wb_data, e.data);
          chk("wb_addr", 32'(bus.wb_addr), 32'(e.rd));
`ifdef MEM_FWD_EN
          chk("fwd_data", bus.fwd_data, e.data);
          chk("fwd_addr", 32'(bus.fwd_addr), 32'(e.rd));
`endif
        end
      end
    end
    @(posedge clk);
    #2;
  endtask

  task automatic drive(logic [OpLen-1:0] op, logic [31:0] a, logic [31:0] d, logic [RegAddrLen-1:0] rd);
    bus.op_i = op; bus.mem_addr_i = a; bus.rd_data_i = d; bus.rd_addr_i = rd;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(string nm);
    int k = 0;
    while (sb_q.size() != 0 && k < 40) begin
      tick();
      k++;
    end
    chk({nm, "_pending"}, 32'(sb_q.size()), 32'h0);
    sb_q.delete();
    tick();
  endtask

  function automatic vec_t mk(string nm, logic [OpLen-1:0] op, logic [31:0] a, logic [31:0] d,
                              logic [RegAddrLen-1:0] rd, logic [31:0] ed, logic [RegAddrLen-1:0] er,
                              int st, int n);
    vec_t v;
    v.name = nm; v.op = op; v.addr = a; v.data = d; v.rd = rd;
    v.exp_data = ed; v.exp_rd = er; v.exp_stall = st; v.exp_n = n;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, l0, w0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h100] = 8'h80; mem[12'h101] = 8'h7F;
    mem[12'hFFF] = 8'h34; mem[12'h000] = 8'h92;
    mem[12'h400] = 8'h11; mem[12'h401] = 8'h22; mem[12'h402] = 8'h33; mem[12'h403] = 8'h44;

    vecs[0]  = mk("add",      OP_ADD, 32'h0,        32'h12345678, 5'd5,  32'h12345678, 5'd5,  0, 0);
    vecs[1]  = mk("sub",      OP_SUB, 32'h0,        32'hDEADBEEF, 5'd31, 32'hDEADBEEF, 5'd31, 0, 0);
    vecs[2]  = mk("nop",      OP_NOP, 32'h0,        32'hCAFEF00D, 5'd1,  32'hCAFEF00D, 5'd1,  0, 0);
    vecs[3]  = mk("lb_neg",   OP_LB,  32'h100,      32'h0,        5'd3,  32'hFFFFFF80, 5'd3,  2, 1);
    vecs[4]  = mk("lbu",      OP_LBU, 32'h100,      32'h0,        5'd4,  32'h00000080, 5'd4,  2, 1);
    vecs[5]  = mk("lb_pos",   OP_LB,  32'h101,      32'h0,        5'd6,  32'h0000007F, 5'd6,  2, 1);
    vecs[6]  = mk("lh_wrap",  OP_LH,  32'hFFFFFFFF, 32'h0,        5'd7,  32'hFFFF9234, 5'd7,  3, 2);
    vecs[7]  = mk("lhu_wrap", OP_LHU, 32'hFFFFFFFF, 32'h0,        5'd8,  32'h00009234, 5'd8,  3, 2);
    vecs[8]  = mk("lw",       OP_LW,  32'h400,      32'h0,        5'd9,  32'h44332211, 5'd9,  5, 4);
    vecs[9]  = mk("sw",       OP_SW,  32'h200,      32'hA1B2C3D4, 5'd10, 32'h0,        5'd0,  5, 4);
    vecs[10] = mk("sb",       OP_SB,  32'h204,      32'h123456EE, 5'd11, 32'h0,        5'd0,  2, 1);
    vecs[11] = mk("sh",       OP_SH,  32'h206,      32'h1234BEEF, 5'd12, 32'h0,        5'd0,  3, 2);

    bus.op_i = '0; bus.mem_addr_i = '0; bus.rd_data_i = '0; bus.rd_addr_i = '0; bus.in_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("rst_mem_req",   {31'b0, bus.mem_req}, 32'h0);
    chk("rst_mem_wr",    {31'b0, bus.mem_wr}, 32'h0);
    chk("rst_mem_a",     bus.mem_a, 32'h0);
    chk("rst_mem_dout",  32'(bus.mem_dout), 32'h0);
    chk("rst_wb_valid",  {31'b0, bus.wb_valid}, 32'h0);
    chk("rst_wb_data",   bus.wb_data, 32'h0);
    chk("rst_wb_addr",   32'(bus.wb_addr), 32'h0);
    chk("rst_mem_stall", {31'b0, bus.mem_stall}, 32'h0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 12; v++) begin
      s0 = stall_cnt; l0 = log_a.size();
      sb_q.push_back('{vecs[v].exp_data, vecs[v].exp_rd});
      drive(vecs[v].op, vecs[v].addr, vecs[v].data, vecs[v].rd);
      drain(vecs[v].name);
      chk({vecs[v].name, "_stall"}, 32'(stall_cnt - s0), 32'(vecs[v].exp_stall));
      chk({vecs[v].name, "_nbytes"}, 32'(log_a.size() - l0), 32'(vecs[v].exp_n));
      for (int i = l0; i < log_a.size(); i++) begin
        chk({vecs[v].name, "_addr"}, log_a[i], vecs[v].addr + 32'(i - l0));
        if (is_store(vecs[v].op))
          chk({vecs[v].name, "_wbyte"}, 32'(log_d[i]), (vecs[v].data >> (8 * (i - l0))) & 32'hFF);
      end
    end

    // New instruction offered while busy must be dropped.
    ack_en = 1'b0; l0 = log_a.size(); w0 = wb_cnt;
    sb_q.push_back('{32'hFFFFFF80, 5'd14});
    drive(OP_LB, 32'h100, 32'h0, 5'd14);
    bus.op_i = OP_ADD; bus.rd_data_i = 32'h0BAD0BAD; bus.rd_addr_i = 5'd15; bus.in_valid = 1'b1;
    tick();
    tick();
    bus.in_valid = 1'b0; ack_en = 1'b1;
    drain("busy_ignore");
    chk("busy_ignore_wbcnt", 32'(wb_cnt - w0), 32'd1);
    chk("busy_ignore_nbytes", 32'(log_a.size() - l0), 32'd1);

    // rdy low for 3 cycles between the first and second byte of a word load.
    ack_en = 1'b0; l0 = log_a.size(); w0 = wb_cnt;
    sb_q.push_back('{32'h44332211, 5'd16});
    drive(OP_LW, 32'h400, 32'h0, 5'd16);
    ack_en = 1'b1;
    tick();
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("frz_mem_a", bus.mem_a, 32'h401);
      chk("frz_mem_req", {31'b0, bus.mem_req}, 32'h1);
      chk("frz_stall", {31'b0, bus.mem_stall}, 32'h1);
      chk("frz_wb_valid", {31'b0, bus.wb_valid}, 32'h0);
    end
    rdy = 1'b1;
    drain("rdy_freeze");
    chk("rdy_freeze_wbcnt", 32'(wb_cnt - w0), 32'd1);
    chk("rdy_freeze_nbytes", 32'(log_a.size() - l0), 32'd4);

    // Reset during the second byte of a store aborts with no writeback.
    l0 = log_a.size(); w0 = wb_cnt;
    drive(OP_SW, 32'h200, 32'h55667788, 5'd13);
    tick();
    rst = 1'b1;
    #1;
    chk("abort_mem_req", {31'b0, bus.mem_req}, 32'h0);
    chk("abort_mem_a", bus.mem_a, 32'h0);
    chk("abort_stall", {31'b0, bus.mem_stall}, 32'h0);
    chk("abort_wb_valid", {31'b0, bus.wb_valid}, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("abort_wbcnt", 32'(wb_cnt - w0), 32'd0);
    chk("abort_nbytes", 32'(log_a.size() - l0), 32'd1);
    chk("abort_byte0", 32'(log_d[l0]), 32'h88);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameters: ADDR_W, 32, address width; DATA_W, 32, register width; BYTE_W, 8, memory-port data width.
REQ-002 clk  in  1  rising-edge system clock.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 rdy  in  1  global enable; low freezes every register and output.
REQ-005 op_i  in  OpLen  op latched from EX stage; mem_addr_i  in  ADDR_W  effective address; rd_data_i  in  DATA_W  ALU result or store data; rd_addr_i  in  RegAddrLen  destination register.
REQ-006 in_valid  in  1  EX/MEM holds a new instruction this cycle.
REQ-007 mem_req  out  1  byte request to memory controller; mem_wr  out  1  1=write; mem_a  out  ADDR_W  byte address; mem_dout  out  BYTE_W  write byte.
REQ-008 mem_ack  in  1  controller completed current byte; mem_din  in  BYTE_W  read byte, valid when mem_ack=1.
REQ-009 wb_valid  out  1  one-cycle pulse, result ready for writeback; wb_data  out  DATA_W; wb_addr  out  RegAddrLen.
REQ-010 mem_stall  out  1  upstream hold request.

Function
REQ-011 FSM states SHALL be IDLE, XFER, DONE.
REQ-012 IDLE, in_valid, non-memory op SHALL produce wb_valid=1 next cycle with wb_data=rd_data_i, wb_addr=rd_addr_i; latency 1; mem_stall stays 0.
REQ-013 IDLE, in_valid, load/store SHALL latch inputs, clear byte counter, set byte count n (B=1, H=2, W=4), go XFER, assert mem_stall same cycle (combinational from in_valid&mem op).
REQ-014 XFER SHALL hold mem_req=1, mem_a=base+cnt, mem_wr=1 for stores, mem_dout=store byte cnt (little-endian, bits 8*cnt+7:8*cnt).
REQ-015 On mem_ack in XFER, loads SHALL capture mem_din into byte lane cnt; cnt increments; at cnt=n-1 go DONE, mem_req drops next cycle.
REQ-016 mem_ack outside XFER SHALL be ignored.
REQ-017 DONE SHALL pulse wb_valid one cycle, deassert mem_stall, return IDLE.
REQ-018 Loads: LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW unchanged.
REQ-019 Stores SHALL drive wb_addr=0 and wb_data=0 with wb_valid=1 (no register write).
REQ-020 Address arithmetic base+cnt SHALL wrap modulo 2^ADDR_W.
REQ-021 in_valid while XFER/DONE SHALL be ignored (upstream is stalled).
REQ-022 rdy=0 SHALL freeze state, counter, outputs; mem_ack sampled only when rdy=1.
REQ-023 wb_valid SHALL be 0 in every cycle other than the completion cycle.

Reset
REQ-024 rst SHALL asynchronously force IDLE, cnt=0, mem_req=0, mem_wr=0, mem_a=0, mem_dout=0, wb_valid=0, wb_data=0, wb_addr=0, mem_stall=0.
REQ-025 rst mid-XFER SHALL abort the access; partial stores are not rolled back; no wb_valid pulse.

Configuration
REQ-026 MEM_FWD_EN defined: outputs fwd_addr (RegAddrLen) and fwd_data (DATA_W) SHALL present the wb_addr/wb_data pair combinationally in the wb_valid cycle, else fwd_addr=0.
REQ-027 MEM_FWD_EN undefined: fwd ports SHALL be absent; all other behaviour identical.

Structure
REQ-028 Op encodings, OpLen, RegAddrLen, ZERO_WORD and state encodings SHALL come from the shared config package/header.
REQ-029 Load extension logic SHALL be sub-module load_ext (op, raw word -> extended word).
REQ-030 Implementation SHALL be single-clock, no latches.

Verification
REQ-031 ADD result 0x12345678, rd=5 -> next cycle wb_valid=1, wb_data=0x12345678, wb_addr=5, mem_stall never 1.
REQ-032 LB addr 0x100, mem_din=0x80 -> one request at 0x100, wb_data=0xFFFFFF80; LBU same -> 0x00000080.
REQ-033 SW addr 0x200 data 0xA1B2C3D4, ack each cycle -> writes D4,C3,B2,A1 to 0x200..0x203, wb_valid with wb_addr=0, stall 5 cycles.
REQ-034 LH addr 0xFFFFFFFF, din 0x34 then 0x92 -> second byte address 0x00000000, wb_data=0xFFFF9234.
REQ-035 LW with rdy low for 3 cycles between acks -> outputs frozen, final wb_data correct, single wb_valid pulse.
REQ-036 rst asserted during 2nd byte of SW -> mem_req=0 immediately, state IDLE, no wb_valid.
